// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and bus helpers shared by the iomem GPIO block.
package gpio_pkg;

    localparam int REG_W = 32;

    localparam logic [7:0] GPIO_OUT      = 8'h00;
    localparam logic [7:0] GPIO_OE       = 8'h04;
    localparam logic [7:0] GPIO_IN       = 8'h08;
    localparam logic [7:0] GPIO_SET      = 8'h0C;
    localparam logic [7:0] GPIO_CLR      = 8'h10;
    localparam logic [7:0] GPIO_TGL      = 8'h14;
    localparam logic [7:0] GPIO_RISE_EN  = 8'h18;
    localparam logic [7:0] GPIO_FALL_EN  = 8'h1C;
    localparam logic [7:0] GPIO_IRQ_STAT = 8'h20;

    function automatic logic [REG_W-1:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-flop input synchroniser plus one history flop for edge detection.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync = r_sync[SYNC_STAGES-1];
    assign rise = sync & ~r_prev;
    assign fall = ~sync & r_prev;

endmodule

// File: rtl/iomem_gpio.sv
// iomem_gpio: GPIO peripheral on the PicoSoC iomem bus with output enables,
// atomic set/clear/toggle and sticky edge interrupts.
module iomem_gpio
    import gpio_pkg::*;
#(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_out, r_oe, r_rise_en, r_fall_en, r_irq_stat;
    logic             r_ready;
    logic [REG_W-1:0] r_rdata, w_rdata, w_bmask;
    logic [WIDTH-1:0] w_sync, w_rise, w_fall, w_m, w_wd, w_evt, w_clr;
    logic             w_sel, w_wr, w_unused;
    logic [7:0]       w_off;

    gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .gpio_in(gpio_in),
        .sync   (w_sync),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    // The !r_ready term makes every accepted request a single-cycle acknowledge.
    assign w_sel   = iomem_valid && !r_ready && iomem_addr[31:24] == BASE_ADDR;
    assign w_wr    = w_sel && |iomem_wstrb;
    assign w_off   = iomem_addr[7:0];
    assign w_bmask = strb_mask(iomem_wstrb);
    assign w_m     = w_bmask[WIDTH-1:0];
    assign w_wd    = iomem_wdata[WIDTH-1:0] & w_m;
    assign w_evt   = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr   = (w_wr && w_off == GPIO_IRQ_STAT) ? w_wd : '0;
    assign w_unused = &{1'b0, iomem_addr[23:8], iomem_wdata, w_bmask};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            GPIO_OUT:      w_rdata = REG_W'(r_out);
            GPIO_OE:       w_rdata = REG_W'(r_oe);
            GPIO_IN:       w_rdata = REG_W'(w_sync);
            GPIO_RISE_EN:  w_rdata = REG_W'(r_rise_en);
            GPIO_FALL_EN:  w_rdata = REG_W'(r_fall_en);
            GPIO_IRQ_STAT: w_rdata = REG_W'(r_irq_stat);
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_out      <= '0;
            r_oe       <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_irq_stat <= '0;
        end else begin
            r_ready    <= w_sel;
            r_rdata    <= w_sel ? w_rdata : '0;
            // New edge events are OR-ed in after the clear so a coincident event wins.
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_evt;
            if (w_wr) begin
                case (w_off)
                    GPIO_OUT:     r_out     <= (r_out & ~w_m) | w_wd;
                    GPIO_OE:      r_oe      <= (r_oe & ~w_m) | w_wd;
                    GPIO_SET:     r_out     <= r_out | w_wd;
                    GPIO_CLR:     r_out     <= r_out & ~w_wd;
                    GPIO_TGL:     r_out     <= r_out ^ w_wd;
                    GPIO_RISE_EN: r_rise_en <= (r_rise_en & ~w_m) | w_wd;
                    GPIO_FALL_EN: r_fall_en <= (r_fall_en & ~w_m) | w_wd;
                    default:      ;
                endcase
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;
    assign irq         = |r_irq_stat;

endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: directed bench for iomem_gpio; expected read data flows
// through a scoreboard queue and is popped when the bus acknowledges.
module tb_iomem_gpio;

    localparam int          WIDTH = 8;
    localparam logic [31:0] BASE  = 32'h0300_0000;

    logic        clk, resetn, iomem_valid, iomem_ready, irq;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic [WIDTH-1:0] gpio_in, gpio_out, gpio_oe;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;

    iomem_gpio #(.WIDTH(WIDTH), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input bit chk_rd, input logic [31:0] exp, input string tag);
        int  n;
        sb_t e;
        if (chk_rd) sbq.push_back('{tag, exp});
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!iomem_ready && n < 20);
        if (!iomem_ready) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            if (chk_rd) void'(sbq.pop_back());
        end else begin
            if (chk_rd) begin
                e = sbq.pop_front();
                check(e.tag, iomem_rdata, e.exp);
            end
            @(posedge clk); #1;
            check({tag, "_pulse"}, 32'(iomem_ready), 32'd0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        xfer(BASE | 32'(off), 4'hF, d, 1'b0, 32'd0, "wr");
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        xfer(BASE | 32'(off), 4'h0, 32'd0, 1'b1, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        gpio_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_out",   32'(gpio_out),    32'd0);
        check("rst_oe",    32'(gpio_oe),     32'd0);
        check("rst_irq",   32'(irq),         32'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        xfer(BASE, 4'b0001, 32'h0000_00A5, 1'b0, 32'd0, "wr_a5");
        check("out_a5", 32'(gpio_out), 32'hA5);
        rd(8'h00, 32'hA5, "rd_out_a5");
        xfer(BASE, 4'b0010, 32'h1234_56FF, 1'b0, 32'd0, "wr_hibyte");
        check("out_hibyte_ignored", 32'(gpio_out), 32'hA5);
        wr(8'h04, 32'hFFFF_FFFF);
        check("oe_ff", 32'(gpio_oe), 32'hFF);
        rd(8'h04, 32'hFF, "rd_oe");

        wr(8'h00, 32'hF0);
        wr(8'h0C, 32'h0F);
        check("set", 32'(gpio_out), 32'hFF);
        wr(8'h10, 32'h30);
        check("clr", 32'(gpio_out), 32'hCF);
        wr(8'h14, 32'h81);
        check("tgl", 32'(gpio_out), 32'h4E);
        rd(8'h0C, 32'd0, "rd_set");
        rd(8'h10, 32'd0, "rd_clr");
        rd(8'h14, 32'd0, "rd_tgl");
        xfer(BASE, 4'hF, 32'd0, 1'b1, 32'h4E, "wr_prewrite_rdata");
        check("out_zero", 32'(gpio_out), 32'd0);

        gpio_in = 8'h3C;
        repeat (4) @(posedge clk);
        rd(8'h08, 32'h3C, "rd_in_3c");
        @(posedge clk); #1;
        gpio_in = 8'h5A;
        rd(8'h08, 32'h3C, "rd_in_latency");
        repeat (3) @(posedge clk);
        rd(8'h08, 32'h5A, "rd_in_5a");
        rd(8'h20, 32'd0, "stat_en_off");
        check("irq_en_off", 32'(irq), 32'd0);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFF;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= iomem_ready;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        check("other_page_noack", 32'(seen), 32'd0);
        check("other_page_nowrite", 32'(gpio_out), 32'd0);
        xfer(BASE | 32'h24, 4'hF, 32'hFF, 1'b1, 32'd0, "unmapped_wr");
        rd(8'h24, 32'd0, "rd_unmapped");

        wr(8'h18, 32'h01);
        wr(8'h1C, 32'h02);
        rd(8'h20, 32'd0, "stat_pre_edge");
        gpio_in = 8'h01;
        repeat (4) @(posedge clk);
        rd(8'h20, 32'h03, "stat_edges");
        check("irq_set", 32'(irq), 32'd1);
        wr(8'h20, 32'h01);
        rd(8'h20, 32'h02, "stat_w1c0");
        check("irq_still", 32'(irq), 32'd1);
        wr(8'h20, 32'h02);
        check("irq_clear", 32'(irq), 32'd0);
        rd(8'h20, 32'd0, "stat_w1c1");

        gpio_in = 8'h00;
        repeat (5) @(posedge clk);
        rd(8'h20, 32'd0, "stat_fall_disabled");
        @(posedge clk); #1;
        gpio_in = 8'h01;
        @(posedge clk);
        @(posedge clk);
        wr(8'h20, 32'h01);
        rd(8'h20, 32'h01, "stat_set_wins");
        check("irq_set_wins", 32'(irq), 32'd1);
        wr(8'h20, 32'h01);

        wr(8'h18, 32'h00);
        wr(8'h1C, 32'h00);
        gpio_in = 8'hFF;
        repeat (5) @(posedge clk);
        gpio_in = 8'h00;
        repeat (5) @(posedge clk);
        rd(8'h20, 32'd0, "stat_enables_zero");
        check("irq_enables_zero", 32'(irq), 32'd0);

        wr(8'h00, 32'hFF);
        wr(8'h18, 32'h01);
        gpio_in = 8'h01;
        repeat (5) @(posedge clk);
        check("pre_rst_out", 32'(gpio_out), 32'hFF);
        check("pre_rst_irq", 32'(irq), 32'd1);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE;
        iomem_wstrb = 4'd0;
        @(posedge clk); #1;
        check("pre_rst_ready", 32'(iomem_ready), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_ready", 32'(iomem_ready), 32'd0);
        check("async_rst_out",   32'(gpio_out),    32'd0);
        check("async_rst_oe",    32'(gpio_oe),     32'd0);
        check("async_rst_irq",   32'(irq),         32'd0);
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
